// File: rtl/rr_prio_arbiter_if.sv
// Request/grant bundle between requesters, the arbiter and the shared consumer.
interface rr_prio_arbiter_if #(
   parameter int N = 8
) ();
   localparam int IDX_WIDTH = $clog2(N);

   logic [N-1:0]         req;
   logic                 rr_en;
   logic                 out_valid;
   logic                 out_ready;
   logic [N-1:0]         grant_onehot;
   logic [IDX_WIDTH-1:0] grant_idx;
   logic [IDX_WIDTH-1:0] ptr;

   // arbiter side
   modport master (
      input  req, rr_en, out_ready,
      output out_valid, grant_onehot, grant_idx, ptr
   );

   // requester/consumer side
   modport slave (
      output req, rr_en, out_ready,
      input  out_valid, grant_onehot, grant_idx, ptr
   );
endinterface

// File: rtl/rr_prio_arbiter.sv
// N-way arbiter: fixed-priority or round-robin winner, registered grant held
// until the consumer accepts it.
//
// state | meaning
// IDLE  | no grant held, out_valid = 0
// HOLD  | grant registers hold the winner, out_valid = 1
module rr_prio_arbiter #(
   parameter int N = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   rr_prio_arbiter_if.master bus
);
   localparam int IDX_WIDTH = $clog2(N);

   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [N-1:0]         grant_onehot_q, grant_onehot_d;
   logic [IDX_WIDTH-1:0] grant_idx_q, grant_idx_d;
   logic [IDX_WIDTH-1:0] ptr_q, ptr_d;

   logic                 accept;
   logic [IDX_WIDTH-1:0] ptr_acc;
   logic [IDX_WIDTH-1:0] start;
   logic                 win_found;
   logic [IDX_WIDTH-1:0] win_idx;
   logic [N-1:0]         win_onehot;

   // pointer value after accepting the held grant, and selection start point
   always_comb begin
      accept  = (state_q == HOLD) && bus.out_ready;
      ptr_acc = (grant_idx_q == IDX_WIDTH'(N - 1)) ? '0 : grant_idx_q + IDX_WIDTH'(1);
      start   = accept ? ptr_acc : ptr_q;
   end

   // winner: lowest set index at or above start, else wrap to lowest set index;
   // with rr_en low the start restriction is dropped, giving lowest-index priority
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = 0; i < N; i++) begin
         if (!win_found && bus.req[i] && (!bus.rr_en || i >= int'(start))) begin
            win_found = 1'b1;
            win_idx   = IDX_WIDTH'(i);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!win_found && bus.req[i]) begin
            win_found = 1'b1;
            win_idx   = IDX_WIDTH'(i);
         end
      end
      win_onehot = {{(N-1){1'b0}}, 1'b1} << win_idx;
   end

   // next-state, grant and pointer update
   always_comb begin
      state_d        = state_q;
      grant_onehot_d = grant_onehot_q;
      grant_idx_d    = grant_idx_q;
      ptr_d          = ptr_q;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d        = HOLD;
               grant_onehot_d = win_onehot;
               grant_idx_d    = win_idx;
            end
         end
         HOLD: begin
            if (accept) begin
               ptr_d = ptr_acc;
               if (win_found) begin
                  grant_onehot_d = win_onehot;
                  grant_idx_d    = win_idx;
               end else begin
                  state_d        = IDLE;
                  grant_onehot_d = '0;
                  grant_idx_d    = '0;
               end
            end
         end
         default: begin
            state_d        = IDLE;
            grant_onehot_d = '0;
            grant_idx_d    = '0;
         end
      endcase
   end

   // state registers, cleared asynchronously so a held grant is dropped at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         grant_onehot_q <= '0;
         grant_idx_q    <= '0;
         ptr_q          <= '0;
      end else begin
         state_q        <= state_d;
         grant_onehot_q <= grant_onehot_d;
         grant_idx_q    <= grant_idx_d;
         ptr_q          <= ptr_d;
      end
   end

   assign bus.out_valid    = (state_q == HOLD);
   assign bus.grant_onehot = grant_onehot_q;
   assign bus.grant_idx    = grant_idx_q;
   assign bus.ptr          = ptr_q;

endmodule

// File: tb/tb_rr_prio_arbiter.sv
// Bench for rr_prio_arbiter at N=5: directed scenarios followed by random
// traffic, all compared against a rotate-and-search reference model.
module tb_rr_prio_arbiter;
   localparam int N = 5;

   logic clk;
   logic rst_n;

   rr_prio_arbiter_if #(.N(N)) ifc ();

   rr_prio_arbiter #(.N(N)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks;
   int n_fails;

   // reference state
   bit m_valid;
   int m_idx;
   int m_ptr;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // search the request vector circularly starting at 'start'
   function automatic int pick(input logic [N-1:0] r, input int start);
      for (int k = 0; k < N; k++) begin
         int j;
         j = (start + k) % N;
         if (r[j]) return j;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_valid = 1'b0;
      m_idx   = 0;
      m_ptr   = 0;
   endtask

   task automatic check_outputs(input string tag);
      check_val({tag, ".valid"}, 32'(ifc.out_valid), 32'(m_valid));
      check_val({tag, ".idx"},   32'(ifc.grant_idx), 32'(m_valid ? m_idx : 0));
      check_val({tag, ".onehot"}, 32'(ifc.grant_onehot), m_valid ? (32'd1 << m_idx) : 32'd0);
      check_val({tag, ".ptr"},   32'(ifc.ptr), 32'(m_ptr));
   endtask

   // apply inputs for one clock, advance the model, check just after the edge
   task automatic cycle(input string tag, input logic [N-1:0] r, input bit rr, input bit rdy);
      ifc.req       = r;
      ifc.rr_en     = rr;
      ifc.out_ready = rdy;
      if (!m_valid || rdy) begin
         if (m_valid) m_ptr = (m_idx + 1) % N;
         if (r != '0) begin
            m_valid = 1'b1;
            m_idx   = pick(r, rr ? m_ptr : 0);
         end else begin
            m_valid = 1'b0;
            m_idx   = 0;
         end
      end
      @(posedge clk);
      #1;
      check_outputs(tag);
   endtask

   initial begin
      n_checks = 0;
      n_fails  = 0;
      model_reset();

      // 1: reset with all requests asserted
      rst_n         = 1'b0;
      ifc.req       = 5'b11111;
      ifc.rr_en     = 1'b1;
      ifc.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_outputs("rst");
      rst_n = 1'b1;
      cycle("rst_first", 5'b11111, 1'b1, 1'b1);
      check_val("rst_first_idx0", 32'(ifc.grant_idx), 32'd0);

      // 2: round-robin over all requesters
      for (int c = 0; c < 6; c++) cycle("rr_all", 5'b11111, 1'b1, 1'b1);
      check_val("rr_all_end_idx", 32'(ifc.grant_idx), 32'd1);

      // 3: fixed priority, pointer follows the accepted index 1
      for (int c = 0; c < 4; c++) cycle("fixed", 5'b10110, 1'b0, 1'b1);
      check_val("fixed_ptr", 32'(ifc.ptr), 32'd2);

      // 4: locked grant while the consumer stalls
      cycle("drain", 5'b00000, 1'b1, 1'b1);
      cycle("lock_load", 5'b01000, 1'b1, 1'b0);
      for (int c = 0; c < 3; c++) cycle("lock_hold", 5'b00000, 1'b1, 1'b0);
      check_val("lock_idx3", 32'(ifc.grant_idx), 32'd3);
      cycle("lock_accept", 5'b00000, 1'b1, 1'b1);
      check_val("lock_ptr4", 32'(ifc.ptr), 32'd4);

      // 5: wrap-around from ptr=4
      cycle("wrap0", 5'b00101, 1'b1, 1'b1);
      check_val("wrap_first_idx", 32'(ifc.grant_idx), 32'd0);
      for (int c = 0; c < 3; c++) cycle("wrap", 5'b00101, 1'b1, 1'b1);
      check_val("wrap_last_ptr", 32'(ifc.ptr), 32'd1);

      // 6: asynchronous reset while holding idx 2
      rst_n = 1'b0;
      #2;
      model_reset();
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) cycle("pre_async", 5'b11111, 1'b1, 1'b1);
      cycle("hold2", 5'b00000, 1'b1, 1'b0);
      check_val("hold2_idx", 32'(ifc.grant_idx), 32'd2);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs("async_rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // random traffic, including mode flips while holding
      for (int c = 0; c < 400; c++) begin
         cycle("rand", N'($urandom_range(0, (1 << N) - 1)),
               1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
